l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Shares the single L2 request port between the instruction cache (ic_) and the data cache (dc_).
- Round-robin arbitration with grant locking. A granted cache keeps the port for a whole multi-word line fill or writeback until it drops its request.
- Muxes the granted cache's request onto the L2 port and routes L2 responses back to the granted cache only.
- Sits between the icache/dcache l2_* ports and the L2/memory model.

Parameters:
- XLEN, 32, address and data width in bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset; asynchronous, active-high.
- ic_l2_req_address  input  XLEN  icache request address.
- ic_l2_req_type  input  memory_operation_e  icache request type (LOAD/STORE).
- ic_l2_req_valid  input  1  icache request pending.
- ic_l2_word_to_store  input  XLEN  icache store data.
- ic_l2_fetched_word  output  XLEN  L2 data returned to icache.
- ic_l2_fetched_word_valid  output  1  icache request completed this cycle.
- ic_l2_grant  output  1  icache owns the L2 port.
- dc_l2_req_address, dc_l2_req_type, dc_l2_req_valid, dc_l2_word_to_store, dc_l2_fetched_word, dc_l2_fetched_word_valid, dc_l2_grant: same directions, widths and meanings as the ic_ ports, for the dcache.
- l2_req_address  output  XLEN  to L2.
- l2_req_type  output  memory_operation_e  to L2.
- l2_req_valid  output  1  to L2.
- l2_word_to_store  output  XLEN  to L2.
- l2_fetched_word  input  XLEN  from L2.
- l2_fetched_word_valid  input  1  from L2; completion of the current beat (LOAD: data valid; STORE: accepted).

Behaviour:
- State machine: IDLE, GRANT_IC, GRANT_DC. Registered state plus 1-bit rr_last (last granted cache).
- Reset (async, immediate): state=IDLE, rr_last=IC (so the first tie goes to dcache).
- All outputs are combinational from state and inputs. While reset is asserted, or in IDLE:
  - l2_req_valid=0, l2_req_address=0, l2_word_to_store=0, l2_req_type=LOAD.
  - both grants=0, both *_fetched_word_valid=0.
- IDLE transitions:
  - Only ic valid -> GRANT_IC.
  - Only dc valid -> GRANT_DC.
  - Both valid -> grant the one not equal to rr_last.
  - Neither valid -> stay in IDLE.
  - On entering a grant state, rr_last is set to the granted cache.
- GRANT_x outputs:
  - l2_req_* = x's request fields; l2_req_valid = x_l2_req_valid.
  - x_l2_grant=1.
  - x_l2_fetched_word_valid = l2_fetched_word_valid.
- GRANT_x transitions:
  - x_l2_req_valid=0 at a posedge -> IDLE.
  - Otherwise stay. The grant locks across any number of beats, and the address/type may change between beats.
- Latency:
  - Request first seen at posedge N in IDLE -> l2_req_valid=1 during cycle N+1.
  - Release costs exactly one IDLE bubble cycle before the next grant.
  - No back-to-back handoff without that bubble.
- Both *_l2_fetched_word outputs always equal l2_fetched_word. The non-granted cache's *_fetched_word_valid is forced to 0, even if l2_fetched_word_valid is high.
- The non-granted cache sees no effect; its request remains pending and must be held stable by the requester.
- Simultaneous release and new request by the same cache: the release wins; the cache re-arbitrates in IDLE against rr_last.
- No preemption: a locked cache can hold the port indefinitely. Starvation is bounded only by the requester deasserting valid between fills.
- Reset mid-transaction: the grant drops and l2_req_valid goes to 0 immediately. The in-flight L2 response is discarded (no valid routed to either cache).
- Assertions (bench-side):
  - ic_l2_grant and dc_l2_grant are never both 1.
  - l2_req_valid implies exactly one grant.

Test Plan:
- Reset held 5 clks, then released with no requests -> l2_req_valid=0, grants=0, state IDLE for 10 clks.
- dc only: dc LOAD 0x0000_0100, 4 beats (addresses 0x100/0x104/0x108/0x10C), L2 returns mem words -> dc_l2_grant=1 from cycle+1 through all beats; dc_l2_fetched_word_valid on each beat; ic_l2_fetched_word_valid=0 throughout.
- Tie after reset: ic and dc both assert at the same posedge -> dc granted first. After dc drops valid: one IDLE cycle, then ic granted.
- Round-robin: both requesting continuously with 2-beat fills, over 6 grants -> order DC, IC, DC, IC, DC, IC; no two consecutive grants to the same cache.
- Lock: ic granted mid 4-beat fill while dc asserts STORE 0x200 data 0xDEAD_BEEF -> l2_req_address stays on the ic addresses until ic releases; then l2_req_type=STORE, addr 0x200, l2_word_to_store=0xDEAD_BEEF.
- Reset asserted while GRANT_DC with l2_fetched_word_valid high -> in the same cycle l2_req_valid=0, dc_l2_grant=0, dc_l2_fetched_word_valid=0. After release, the pending request is re-arbitrated from IDLE with dc preferred.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single L2 request port between icache and dcache.
// Round-robin on ties; a granted cache keeps the port until it drops its request.
module l2_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ic_l2_req_address,
  input  logic            ic_l2_req_type,
  input  logic            ic_l2_req_valid,
  input  logic [XLEN-1:0] ic_l2_word_to_store,
  output logic [XLEN-1:0] ic_l2_fetched_word,
  output logic            ic_l2_fetched_word_valid,
  output logic            ic_l2_grant,
  input  logic [XLEN-1:0] dc_l2_req_address,
  input  logic            dc_l2_req_type,
  input  logic            dc_l2_req_valid,
  input  logic [XLEN-1:0] dc_l2_word_to_store,
  output logic [XLEN-1:0] dc_l2_fetched_word,
  output logic            dc_l2_fetched_word_valid,
  output logic            dc_l2_grant,
  output logic [XLEN-1:0] l2_req_address,
  output logic            l2_req_type,
  output logic            l2_req_valid,
  output logic [XLEN-1:0] l2_word_to_store,
  input  logic [XLEN-1:0] l2_fetched_word,
  input  logic            l2_fetched_word_valid
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IC = 2'd1,
    GRANT_DC = 2'd2
  } state_e;

  localparam logic RR_IC   = 1'b0;
  localparam logic RR_DC   = 1'b1;
  localparam logic OP_LOAD = 1'b0;

  state_e state_r;
  state_e state_s;
  logic   rr_last_r;

  // State register and last-granted pointer; reset leaves ic as last so dc wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      rr_last_r <= RR_IC;
    end else begin
      state_r <= state_s;
      if (state_s == GRANT_IC) begin
        rr_last_r <= RR_IC;
      end else if (state_s == GRANT_DC) begin
        rr_last_r <= RR_DC;
      end else begin
        rr_last_r <= rr_last_r;
      end
    end
  end

  // Next-state: arbitrate only from IDLE, so every release costs one bubble cycle
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ic_l2_req_valid && dc_l2_req_valid) begin
          state_s = (rr_last_r == RR_IC) ? GRANT_DC : GRANT_IC;
        end else if (ic_l2_req_valid) begin
          state_s = GRANT_IC;
        end else if (dc_l2_req_valid) begin
          state_s = GRANT_DC;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_IC: begin
        if (!ic_l2_req_valid) begin
          state_s = IDLE;
        end else begin
          state_s = GRANT_IC;
        end
      end
      GRANT_DC: begin
        if (!dc_l2_req_valid) begin
          state_s = IDLE;
        end else begin
          state_s = GRANT_DC;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output mux; reset forces IDLE asynchronously, which also blanks every output
  always_comb begin
    l2_req_address           = {XLEN{1'b0}};
    l2_req_type              = OP_LOAD;
    l2_req_valid             = 1'b0;
    l2_word_to_store         = {XLEN{1'b0}};
    ic_l2_grant              = 1'b0;
    dc_l2_grant              = 1'b0;
    ic_l2_fetched_word_valid = 1'b0;
    dc_l2_fetched_word_valid = 1'b0;
    case (state_r)
      GRANT_IC: begin
        l2_req_address           = ic_l2_req_address;
        l2_req_type              = ic_l2_req_type;
        l2_req_valid             = ic_l2_req_valid;
        l2_word_to_store         = ic_l2_word_to_store;
        ic_l2_grant              = 1'b1;
        ic_l2_fetched_word_valid = l2_fetched_word_valid;
      end
      GRANT_DC: begin
        l2_req_address           = dc_l2_req_address;
        l2_req_type              = dc_l2_req_type;
        l2_req_valid             = dc_l2_req_valid;
        l2_word_to_store         = dc_l2_word_to_store;
        dc_l2_grant              = 1'b1;
        dc_l2_fetched_word_valid = l2_fetched_word_valid;
      end
      default: begin
        l2_req_valid = 1'b0;
      end
    endcase
  end

  assign ic_l2_fetched_word = l2_fetched_word;
  assign dc_l2_fetched_word = l2_fetched_word;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: vector table, directed corner sequences and random traffic
// checked against an owner/last-winner reference model.
module tb_l2_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ic_addr, ic_wts, dc_addr, dc_wts, l2_fw;
  logic        ic_type, ic_v, dc_type, dc_v, l2_fv;
  logic [31:0] ic_fw, dc_fw, l2_addr, l2_wts;
  logic        ic_fv, ic_g, dc_fv, dc_g, l2_type, l2_v;

  int checks = 0;
  int errors = 0;

  l2_arbiter #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .ic_l2_req_address(ic_addr), .ic_l2_req_type(ic_type), .ic_l2_req_valid(ic_v),
    .ic_l2_word_to_store(ic_wts), .ic_l2_fetched_word(ic_fw),
    .ic_l2_fetched_word_valid(ic_fv), .ic_l2_grant(ic_g),
    .dc_l2_req_address(dc_addr), .dc_l2_req_type(dc_type), .dc_l2_req_valid(dc_v),
    .dc_l2_word_to_store(dc_wts), .dc_l2_fetched_word(dc_fw),
    .dc_l2_fetched_word_valid(dc_fv), .dc_l2_grant(dc_g),
    .l2_req_address(l2_addr), .l2_req_type(l2_type), .l2_req_valid(l2_v),
    .l2_word_to_store(l2_wts), .l2_fetched_word(l2_fw), .l2_fetched_word_valid(l2_fv)
  );

  always #5 clk = ~clk;

  // Reference model: owner 0=none 1=ic 2=dc, last = most recent winner
  int owner_m;
  int last_m;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_m <= 0;
      last_m  <= 1;
    end else if (owner_m == 0) begin
      if (ic_v && dc_v) begin
        owner_m <= 3 - last_m;
        last_m  <= 3 - last_m;
      end else if (ic_v) begin
        owner_m <= 1;
        last_m  <= 1;
      end else if (dc_v) begin
        owner_m <= 2;
        last_m  <= 2;
      end
    end else if ((owner_m == 1 && !ic_v) || (owner_m == 2 && !dc_v)) begin
      owner_m <= 0;
    end
  end

  function automatic logic [133:0] expect_outputs();
    int own;
    own = reset ? 0 : owner_m;
    if (own == 1)
      return {1'b1, 1'b0, ic_v, ic_type, l2_fv, 1'b0, ic_addr, ic_wts, l2_fw, l2_fw};
    else if (own == 2)
      return {1'b0, 1'b1, dc_v, dc_type, 1'b0, l2_fv, dc_addr, dc_wts, l2_fw, l2_fw};
    else
      return {6'd0, 64'd0, l2_fw, l2_fw};
  endfunction

  function automatic logic [133:0] actual_outputs();
    return {ic_g, dc_g, l2_v, l2_type, ic_fv, dc_fv, l2_addr, l2_wts, ic_fw, dc_fw};
  endfunction

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    chk(name, actual_outputs(), expect_outputs());
    chk({name, "_onehot"}, {133'd0, ic_g & dc_g}, 134'd0);
    chk({name, "_validgrant"}, {133'd0, l2_v & ~(ic_g ^ dc_g)}, 134'd0);
  endtask

  typedef struct {
    logic ic_v, dc_v, fv;
    logic ic_g, dc_g, l2_v, ic_fv, dc_fv;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[16];

  int ic_beats, dc_beats, ng;
  logic prev_ic, prev_dc;
  int order[6];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2000};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2000};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2000};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    reset = 1'b1;
    ic_v = 1'b0; dc_v = 1'b0; l2_fv = 1'b0;
    ic_type = 1'b0; dc_type = 1'b0;
    ic_addr = 32'h1000; dc_addr = 32'h2000;
    ic_wts = 32'h1111_0000; dc_wts = 32'h2222_0000;
    l2_fw = 32'h5A5A_0001;

    // Reset held 5 clocks, then 10 idle clocks
    repeat (5) begin
      @(negedge clk); #1;
      chk_model("in_reset");
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle_after_reset", {129'd0, ic_g, dc_g, l2_v, ic_fv, dc_fv}, 134'd0);
      chk_model("idle_model");
    end

    // Tie, bubble and round-robin vectors
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ic_v = tbl[i].ic_v; dc_v = tbl[i].dc_v; l2_fv = tbl[i].fv;
      #1;
      chk($sformatf("table_row%0d", i),
          {97'd0, ic_g, dc_g, l2_v, ic_fv, dc_fv, l2_addr},
          {97'd0, tbl[i].ic_g, tbl[i].dc_g, tbl[i].l2_v, tbl[i].ic_fv, tbl[i].dc_fv, tbl[i].addr});
      chk_model("table_model");
    end

    // dc-only 4-beat line fill
    @(negedge clk);
    dc_v = 1'b1; dc_type = 1'b0; dc_addr = 32'h100; l2_fv = 1'b0;
    #1 chk_model("dc_req_idle");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dc_addr = 32'h100 + 32'(4 * i);
      l2_fw = 32'hA000_0000 + 32'(i);
      l2_fv = 1'b1;
      #1;
      chk("dc_beat", {66'd0, dc_g, dc_fv, ic_fv, l2_v, l2_addr, dc_fw},
          {66'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i)});
      chk_model("dc_beat_model");
    end
    @(negedge clk);
    dc_v = 1'b0; l2_fv = 1'b0;
    #1 chk_model("dc_release");
    @(negedge clk); #1 chk_model("dc_bubble");

    // Lock: ic fill holds the port while dc waits with a STORE
    @(negedge clk);
    ic_v = 1'b1; ic_type = 1'b0; ic_addr = 32'h300;
    #1 chk_model("lock_ic_req");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ic_addr = 32'h300 + 32'(4 * i);
      l2_fv = 1'b1;
      if (i >= 1) begin
        dc_v = 1'b1; dc_type = 1'b1; dc_addr = 32'h200; dc_wts = 32'hDEAD_BEEF;
      end
      #1;
      chk("lock_hold", {99'd0, ic_g, dc_g, dc_fv, l2_addr},
          {99'd0, 1'b1, 1'b0, 1'b0, 32'h300 + 32'(4 * i)});
      chk_model("lock_model");
    end
    @(negedge clk);
    ic_v = 1'b0; l2_fv = 1'b0;
    #1 chk_model("lock_release");
    @(negedge clk); #1;
    chk("lock_bubble", {131'd0, ic_g, dc_g, l2_v}, 134'd0);
    @(negedge clk); #1;
    chk("store_granted", {67'd0, dc_g, l2_v, l2_type, l2_addr, l2_wts},
        {67'd0, 1'b1, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF});
    chk_model("store_model");

    // Reset while GRANT_DC with a response in flight
    @(negedge clk);
    l2_fv = 1'b1; ic_v = 1'b1; ic_addr = 32'h400;
    #1 chk_model("pre_reset_beat");
    reset = 1'b1;
    #1;
    chk("reset_mid", {129'd0, l2_v, dc_g, dc_fv, ic_g, ic_fv}, 134'd0);
    chk_model("reset_mid_model");
    @(negedge clk);
    reset = 1'b0; l2_fv = 1'b0;
    #1 chk_model("reset_release");
    @(negedge clk); #1;
    chk("rearb_dc_first", {132'd0, ic_g, dc_g}, {132'd0, 1'b0, 1'b1});
    chk_model("rearb_model");
    @(negedge clk);
    ic_v = 1'b0; dc_v = 1'b0; dc_type = 1'b0;

    // Round-robin: both caches request continuously, 2-beat fills
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ic_beats = 0; dc_beats = 0; ng = 0; prev_ic = 1'b0; prev_dc = 1'b0;
    for (int c = 0; c < 100 && ng < 6; c++) begin
      @(negedge clk);
      if (ic_g && !prev_ic) begin order[ng] = 1; ng++; end
      if (dc_g && !prev_dc && ng < 6) begin order[ng] = 2; ng++; end
      prev_ic = ic_g; prev_dc = dc_g;
      if (ic_g && ic_beats == 2) begin ic_v = 1'b0; ic_beats = 0; end
      else ic_v = 1'b1;
      if (dc_g && dc_beats == 2) begin dc_v = 1'b0; dc_beats = 0; end
      else dc_v = 1'b1;
      l2_fv = (ic_g && ic_v) || (dc_g && dc_v);
      if (ic_g && ic_v) ic_beats++;
      if (dc_g && dc_v) dc_beats++;
      #1 chk_model("rr_model");
    end
    chk("rr_grant_count", 134'(ng), 134'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i), 134'(order[i]), (i % 2 == 0) ? 134'd2 : 134'd1);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 49) == 0);
      ic_v    = ($urandom_range(0, 3) != 0);
      dc_v    = ($urandom_range(0, 3) != 0);
      ic_type = 1'($urandom_range(0, 1));
      dc_type = 1'($urandom_range(0, 1));
      ic_addr = $urandom; dc_addr = $urandom;
      ic_wts  = $urandom; dc_wts  = $urandom;
      l2_fw   = $urandom;
      l2_fv   = 1'($urandom_range(0, 1));
      #1 chk_model("random");
    end

    @(negedge clk);
    reset = 1'b0; ic_v = 1'b0; dc_v = 1'b0; l2_fv = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
